// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial borrow subtractor.
// Optional signed overflow output is enabled with SIGNED_OVF_EN.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 4;

   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin.
// Iterated over the operand bits by serial_borrow_sub.
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_borrow_sub.sv
// Bit-serial D = A - B - Bin, LSB first, valid/ready on both sides.
// Define SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_borrow_sub
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state, state_n;

   logic [WIDTH-1:0] sa, sb, acc, d_q;
   logic [CW-1:0]    cnt;
   logic             brw, bout_q;
   logic             dbit, bnext;
   logic             last;

   full_sub_bit u_cell (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (brw),
      .d    (dbit),
      .bout (bnext)
   );

   assign last = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = SHIFT;
         end
         SHIFT: begin
            if (last) state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // acc collects difference bits; d_q only changes when a result completes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         acc    <= '0;
         d_q    <= '0;
         cnt    <= '0;
         brw    <= 1'b0;
         bout_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sa  <= a;
                  sb  <= b;
                  brw <= bin;
                  cnt <= '0;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               acc <= {dbit, acc[WIDTH-1:1]};
               brw <= bnext;
               cnt <= cnt + 1'b1;
               if (last) begin
                  d_q    <= {dbit, acc[WIDTH-1:1]};
                  bout_q <= bnext;
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = d_q;
   assign bout = bout_q;

`ifdef SIGNED_OVF_EN
   logic ovf_q;

   // On the last bit sa[0]/sb[0] are the operand sign bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state == SHIFT && last) begin
         ovf_q <= (sa[0] ^ sb[0]) & (dbit ^ sa[0]);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
